// File: rtl/apb_master.sv
// apb_master
// APB initiator that turns a valid/ready command interface into APB
// SETUP/ACCESS transfers towards up to NUM_SLV slaves on the PCLK domain.
// Out-of-range slots and slaves that never raise PREADY both come back as
// error responses, so the bus can never hang.
//
// Ports:
//   PCLK, PRESET         clock and synchronous active-high reset
//   req_valid/req_ready  command handshake (req_write, req_addr, req_wdata)
//   rsp_valid            one-cycle response pulse with rsp_rdata, rsp_err
//   PADDR/PWDATA/PWRITE  APB address, write data and direction
//   PENABLE, PSEL        APB enable and one-hot slave select
//   PRDATA_i, PREADY_i   packed per-slave read data and ready inputs
module apb_master #(
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic [31:0]             PADDR,
  output logic [31:0]             PWDATA,
  output logic                    PWRITE,
  output logic                    PENABLE,
  output logic [NUM_SLV-1:0]      PSEL,
  input  logic [32*NUM_SLV-1:0]   PRDATA_i,
  input  logic [NUM_SLV-1:0]      PREADY_i
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t               r_state;
  logic                 r_reqReady;
  logic                 r_rspValid;
  logic                 r_rspErr;
  logic [31:0]          r_rspRdata;
  logic                 r_decErrPend;
  logic [31:0]          r_paddr;
  logic [31:0]          r_pwdata;
  logic                 r_pwrite;
  logic                 r_penable;
  logic [NUM_SLV-1:0]   r_psel;
  logic [CNT_W-1:0]     r_waitCnt;

  logic [NUM_SLV-1:0]   w_selDecode;
  logic                 w_slotOk;
  logic                 w_ready;
  logic [31:0]          w_rdata;

  // One-hot decode of the incoming slot; an all-zero result means the
  // slot is beyond NUM_SLV and the command becomes a decode error.
  always_comb begin
    w_selDecode = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      w_selDecode[k] = (req_addr[15:12] == 4'(k));
    end
  end

  assign w_slotOk = |w_selDecode;

  // The registered one-hot PSEL doubles as the mux select, so only the
  // active slave's PREADY/PRDATA are ever observed.
  always_comb begin
    w_ready = 1'b0;
    w_rdata = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (r_psel[k]) begin
        w_ready = w_ready | PREADY_i[k];
        w_rdata = w_rdata | PRDATA_i[32*k +: 32];
      end
    end
  end

  // Transfer FSM with every output registered. A decode error is held in
  // r_decErrPend for one cycle so its response pulse lands one cycle after
  // the acceptance cycle, matching the spacing of a normal transfer.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state      <= IDLE;
      r_reqReady   <= 1'b0;
      r_rspValid   <= 1'b0;
      r_rspErr     <= 1'b0;
      r_rspRdata   <= '0;
      r_decErrPend <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_pwrite     <= 1'b0;
      r_penable    <= 1'b0;
      r_psel       <= '0;
      r_waitCnt    <= '0;
    end else begin
      r_rspValid   <= 1'b0;
      r_decErrPend <= 1'b0;
      if (r_decErrPend) begin
        r_rspValid <= 1'b1;
        r_rspErr   <= 1'b1;
        r_rspRdata <= '0;
      end
      case (r_state)
        IDLE: begin
          r_reqReady <= 1'b1;
          if (req_valid && r_reqReady) begin
            r_paddr  <= req_addr;
            r_pwdata <= req_wdata;
            r_pwrite <= req_write;
            if (w_slotOk) begin
              r_psel     <= w_selDecode;
              r_reqReady <= 1'b0;
              r_state    <= SETUP;
            end else begin
              r_decErrPend <= 1'b1;
            end
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_waitCnt <= '0;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          // PREADY wins over the timeout when both happen on the same edge.
          if (w_ready) begin
            r_rspValid <= 1'b1;
            r_rspErr   <= 1'b0;
            r_rspRdata <= r_pwrite ? 32'h0 : w_rdata;
            r_psel     <= '0;
            r_penable  <= 1'b0;
            r_reqReady <= 1'b1;
            r_state    <= IDLE;
          end else if (r_waitCnt == CNT_W'(TIMEOUT - 1)) begin
            r_rspValid <= 1'b1;
            r_rspErr   <= 1'b1;
            r_rspRdata <= '0;
            r_psel     <= '0;
            r_penable  <= 1'b0;
            r_reqReady <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_waitCnt <= r_waitCnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_reqReady;
  assign rsp_valid = r_rspValid;
  assign rsp_err   = r_rspErr;
  assign rsp_rdata = r_rspRdata;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign PWRITE    = r_pwrite;
  assign PENABLE   = r_penable;
  assign PSEL      = r_psel;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master
// Drives apb_master with four behavioural slaves:
//   slot 0: FIFO peripheral with registered PREADY (0x0 status, 0x4 push, 0x8 pop)
//   slot 1: PREADY tied low (always times out)
//   slot 2: zero-wait slave, 0xDEADBEEF at 0x2010, else PADDR ^ 0x5A5A0000
//   slot 3: memory slave whose wait-state count is chosen by the bench
module tb_apb_master;

  localparam int NUM_SLV = 4;
  localparam int TIMEOUT = 16;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic          req_ready;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [31:0]   PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE;
  logic          PENABLE;
  logic [3:0]    PSEL;
  logic [127:0]  PRDATA_i;
  logic [3:0]    PREADY_i;

  int nChecks = 0;
  int nFails = 0;

  // slave models
  logic          fifoReady = 1'b0;
  logic [31:0]   fifoMem [0:15];
  int            fifoWr = 0;
  int            fifoRd = 0;
  logic [31:0]   prd0;
  logic [31:0]   prd2;
  logic [31:0]   prd3;
  logic          rdy3;
  logic [31:0]   mem3 [0:63] = '{default: 32'h0};
  int            cnt3 = 0;
  int            wait3 = 0;

  // reference model memory for slot 3
  logic [31:0]   modelMem [0:63] = '{default: 32'h0};

  apb_master #(.NUM_SLV(NUM_SLV), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE),
    .PSEL(PSEL), .PRDATA_i(PRDATA_i), .PREADY_i(PREADY_i)
  );

  always #5 PCLK = ~PCLK;

  // FIFO peripheral: PREADY one cycle after it sees PSEL && PENABLE.
  always @(posedge PCLK) begin
    fifoReady <= PSEL[0] && PENABLE && !fifoReady;
    if (PSEL[0] && PENABLE && fifoReady) begin
      if (PWRITE && PADDR[7:0] == 8'h04) begin
        fifoMem[fifoWr % 16] <= PWDATA;
        fifoWr <= fifoWr + 1;
      end else if (!PWRITE && PADDR[7:0] == 8'h08 && fifoWr != fifoRd) begin
        fifoRd <= fifoRd + 1;
      end
    end
  end

  always_comb begin
    prd0 = 32'h0;
    if (PADDR[7:0] == 8'h00) prd0 = {31'h0, fifoWr == fifoRd};
    else if (PADDR[7:0] == 8'h08 && fifoWr != fifoRd) prd0 = fifoMem[fifoRd % 16];
  end

  assign prd2 = (PADDR == 32'h0000_2010) ? 32'hDEAD_BEEF : (PADDR ^ 32'h5A5A_0000);

  // Memory slave on slot 3 holding PREADY low for wait3 ACCESS cycles.
  assign rdy3 = PSEL[3] && PENABLE && (cnt3 == wait3);
  assign prd3 = mem3[PADDR[7:2]];

  always @(posedge PCLK) begin
    if (PSEL[3] && PENABLE && !rdy3) cnt3 <= cnt3 + 1;
    else cnt3 <= 0;
    if (PSEL[3] && PENABLE && rdy3 && PWRITE) mem3[PADDR[7:2]] <= PWDATA;
  end

  assign PREADY_i = {rdy3, 1'b1, 1'b0, fifoReady};
  assign PRDATA_i = {prd3, prd2, 32'hBAD1_BAD1, prd0};

  // Issue one command and observe it until its response (bounded).
  // lat is the index of the rsp_valid cycle, acceptance cycle being 1.
  task automatic runTxn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] expSel,
                        output int lat, output int pselCyc, output int penCyc, output int readyLow,
                        output logic err, output logic [31:0] rdata, output logic stable,
                        output logic pulseOk, output logic [3:0] selAtRsp);
    int guard;
    @(negedge PCLK);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge PCLK);
      guard++;
    end
    @(negedge PCLK);
    req_valid = 1'b0;
    lat = 1; pselCyc = 0; penCyc = 0; readyLow = 0; stable = 1'b1;
    while (!rsp_valid && lat < 100) begin
      if (|PSEL) begin
        pselCyc++;
        if (PSEL !== expSel || PADDR !== addr || PWDATA !== wdata || PWRITE !== wr) stable = 1'b0;
      end
      if (PENABLE) penCyc++;
      if (!req_ready) readyLow++;
      @(negedge PCLK);
      lat++;
    end
    err = rsp_err;
    rdata = rsp_rdata;
    selAtRsp = PSEL;
    @(negedge PCLK);
    pulseOk = !rsp_valid;
  endtask

  task automatic applyStimulus();
    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
  endtask

  task automatic test_reset();
    applyStimulus();
    nChecks++; if (req_ready !== 1'b0) begin nFails++; $display("[TB] FAIL reset_req_ready: got %0b expected 0", req_ready); end
    nChecks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin nFails++; $display("[TB] FAIL reset_rsp: got v=%0b e=%0b d=%0h expected 0/0/0", rsp_valid, rsp_err, rsp_rdata); end
    nChecks++; if (PADDR !== 32'h0 || PWDATA !== 32'h0 || PWRITE !== 1'b0) begin nFails++; $display("[TB] FAIL reset_apb_data: got a=%0h d=%0h w=%0b expected 0", PADDR, PWDATA, PWRITE); end
    nChecks++; if (PSEL !== 4'h0 || PENABLE !== 1'b0) begin nFails++; $display("[TB] FAIL reset_apb_ctl: got sel=%0h en=%0b expected 0", PSEL, PENABLE); end
    PRESET = 1'b0;
    @(negedge PCLK);
    nChecks++; if (req_ready !== 1'b1) begin nFails++; $display("[TB] FAIL reset_release_ready: got %0b expected 1", req_ready); end
  endtask

  task automatic test_fifo();
    int lat, ps, pe, rl; logic err, st, po; logic [31:0] rd; logic [3:0] sr;
    runTxn(1'b1, 32'h4, 32'hA5, 4'b0001, lat, ps, pe, rl, err, rd, st, po, sr);
    nChecks++; if (ps !== 3) begin nFails++; $display("[TB] FAIL fifo_wr_psel_cycles: got %0d expected 3", ps); end
    nChecks++; if (pe !== 2) begin nFails++; $display("[TB] FAIL fifo_wr_penable_cycles: got %0d expected 2", pe); end
    nChecks++; if (lat !== 4) begin nFails++; $display("[TB] FAIL fifo_wr_latency: got %0d expected 4", lat); end
    nChecks++; if (err !== 1'b0 || rd !== 32'h0) begin nFails++; $display("[TB] FAIL fifo_wr_rsp: got e=%0b d=%0h expected 0/0", err, rd); end
    nChecks++; if (st !== 1'b1 || po !== 1'b1 || sr !== 4'h0) begin nFails++; $display("[TB] FAIL fifo_wr_bus: got stable=%0b pulse=%0b sel=%0h expected 1/1/0", st, po, sr); end
    nChecks++; if (rl !== 3) begin nFails++; $display("[TB] FAIL fifo_wr_ready_low: got %0d expected 3", rl); end
    runTxn(1'b0, 32'h0, 32'h0, 4'b0001, lat, ps, pe, rl, err, rd, st, po, sr);
    nChecks++; if (err !== 1'b0 || rd !== 32'h0) begin nFails++; $display("[TB] FAIL fifo_status_full: got e=%0b d=%0h expected 0/0", err, rd); end
    runTxn(1'b0, 32'h8, 32'h0, 4'b0001, lat, ps, pe, rl, err, rd, st, po, sr);
    nChecks++; if (err !== 1'b0 || rd !== 32'hA5) begin nFails++; $display("[TB] FAIL fifo_pop: got e=%0b d=%0h expected 0/a5", err, rd); end
    runTxn(1'b0, 32'h0, 32'h0, 4'b0001, lat, ps, pe, rl, err, rd, st, po, sr);
    nChecks++; if (err !== 1'b0 || rd !== 32'h1) begin nFails++; $display("[TB] FAIL fifo_status_empty: got e=%0b d=%0h expected 0/1", err, rd); end
  endtask

  task automatic test_zero_wait();
    int lat, ps, pe, rl; logic err, st, po; logic [31:0] rd; logic [3:0] sr;
    runTxn(1'b0, 32'h0000_2010, 32'h0, 4'b0100, lat, ps, pe, rl, err, rd, st, po, sr);
    nChecks++; if (lat !== 3) begin nFails++; $display("[TB] FAIL zw_latency: got %0d expected 3", lat); end
    nChecks++; if (rd !== 32'hDEAD_BEEF || err !== 1'b0) begin nFails++; $display("[TB] FAIL zw_rdata: got e=%0b d=%0h expected 0/deadbeef", err, rd); end
    nChecks++; if (ps !== 2 || pe !== 1 || st !== 1'b1) begin nFails++; $display("[TB] FAIL zw_bus: got psel=%0d pen=%0d stable=%0b expected 2/1/1", ps, pe, st); end
  endtask

  task automatic test_back_to_back();
    int cyc, guard, firstAt, secondAt; logic sawAccept, rdyAtRsp; logic [31:0] d1, d2;
    @(negedge PCLK);
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge PCLK); guard++; end
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_2010; req_wdata = 32'h0;
    @(negedge PCLK);
    req_addr = 32'h0000_2044;
    cyc = 1; firstAt = 0; secondAt = 0; rdyAtRsp = 1'b0; d1 = 32'h0; d2 = 32'h0;
    while (secondAt == 0 && cyc < 40) begin
      if (rsp_valid) begin
        if (firstAt == 0) begin firstAt = cyc; d1 = rsp_rdata; rdyAtRsp = req_ready; end
        else begin secondAt = cyc; d2 = rsp_rdata; end
      end
      sawAccept = req_ready && req_valid;
      @(negedge PCLK);
      cyc++;
      if (sawAccept) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    nChecks++; if (firstAt !== 3 || d1 !== 32'hDEAD_BEEF) begin nFails++; $display("[TB] FAIL b2b_first: got at=%0d d=%0h expected 3/deadbeef", firstAt, d1); end
    nChecks++; if (rdyAtRsp !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_ready_in_rsp: got %0b expected 1", rdyAtRsp); end
    nChecks++; if (secondAt !== 6 || d2 !== (32'h0000_2044 ^ 32'h5A5A_0000)) begin nFails++; $display("[TB] FAIL b2b_second: got at=%0d d=%0h expected 6/%0h", secondAt, d2, 32'h0000_2044 ^ 32'h5A5A_0000); end
  endtask

  task automatic test_timeout();
    int lat, ps, pe, rl; logic err, st, po; logic [31:0] rd; logic [3:0] sr;
    runTxn(1'b0, 32'h0000_1000, 32'h0, 4'b0010, lat, ps, pe, rl, err, rd, st, po, sr);
    nChecks++; if (pe !== TIMEOUT || ps !== TIMEOUT + 1) begin nFails++; $display("[TB] FAIL to_cycles: got pen=%0d psel=%0d expected %0d/%0d", pe, ps, TIMEOUT, TIMEOUT + 1); end
    nChecks++; if (err !== 1'b1 || rd !== 32'h0) begin nFails++; $display("[TB] FAIL to_rsp: got e=%0b d=%0h expected 1/0", err, rd); end
    nChecks++; if (sr !== 4'h0 || lat !== TIMEOUT + 2 || po !== 1'b1) begin nFails++; $display("[TB] FAIL to_end: got sel=%0h lat=%0d pulse=%0b expected 0/%0d/1", sr, lat, po, TIMEOUT + 2); end
  endtask

  task automatic test_decode();
    int lat, ps, pe, rl; logic err, st, po; logic [31:0] rd; logic [3:0] sr;
    runTxn(1'b1, 32'h0000_7000, 32'h55, 4'b0000, lat, ps, pe, rl, err, rd, st, po, sr);
    nChecks++; if (ps !== 0 || pe !== 0 || sr !== 4'h0) begin nFails++; $display("[TB] FAIL dec_psel: got psel=%0d pen=%0d expected 0/0", ps, pe); end
    nChecks++; if (lat !== 2 || err !== 1'b1 || rd !== 32'h0) begin nFails++; $display("[TB] FAIL dec_rsp: got lat=%0d e=%0b d=%0h expected 2/1/0", lat, err, rd); end
    nChecks++; if (rl !== 0 || po !== 1'b1) begin nFails++; $display("[TB] FAIL dec_ready: got lowCycles=%0d pulse=%0b expected 0/1", rl, po); end
  endtask

  // Slot 3 wait counts straddling the timeout limit.
  task automatic test_timeout_boundary();
    int lat, ps, pe, rl; logic err, st, po; logic [31:0] rd; logic [3:0] sr;
    wait3 = TIMEOUT - 1;
    runTxn(1'b1, 32'h0000_3014, 32'h1357_9BDF, 4'b1000, lat, ps, pe, rl, err, rd, st, po, sr);
    modelMem[5] = 32'h1357_9BDF;
    nChecks++; if (pe !== TIMEOUT || err !== 1'b0) begin nFails++; $display("[TB] FAIL bnd_last_cycle_ok: got pen=%0d e=%0b expected %0d/0", pe, err, TIMEOUT); end
    wait3 = TIMEOUT;
    runTxn(1'b1, 32'h0000_3014, 32'hFFFF_0000, 4'b1000, lat, ps, pe, rl, err, rd, st, po, sr);
    nChecks++; if (pe !== TIMEOUT || err !== 1'b1) begin nFails++; $display("[TB] FAIL bnd_one_late: got pen=%0d e=%0b expected %0d/1", pe, err, TIMEOUT); end
    wait3 = 2;
    runTxn(1'b0, 32'h0000_3014, 32'h0, 4'b1000, lat, ps, pe, rl, err, rd, st, po, sr);
    nChecks++; if (rd !== modelMem[5] || err !== 1'b0 || lat !== 5) begin nFails++; $display("[TB] FAIL bnd_readback: got d=%0h e=%0b lat=%0d expected %0h/0/5", rd, err, lat, modelMem[5]); end
  endtask

  // Random commands over slots 1..3 and undecoded slots, predicted by
  // the transfer rules: access cycles = min(waits + 1, TIMEOUT).
  task automatic test_random();
    int lat, ps, pe, rl, kind, nAcc, idx; logic err, st, po, wr, expErr, dec; logic [31:0] rd, addr, wd, expData; logic [3:0] sr, expSel;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      wr = 1'(($urandom & 1));
      wd = $urandom;
      idx = $urandom_range(0, 63);
      wait3 = $urandom_range(0, 17);
      dec = 1'b0;
      if (kind < 4) begin
        addr = {16'($urandom), 4'h3, 4'h0, 6'(idx), 2'b00};
        expSel = 4'b1000;
        nAcc = (wait3 + 1 <= TIMEOUT) ? wait3 + 1 : TIMEOUT;
        expErr = (wait3 + 1 > TIMEOUT);
        expData = (wr || expErr) ? 32'h0 : modelMem[idx];
        if (wr && !expErr) modelMem[idx] = wd;
      end else if (kind < 8) begin
        addr = {16'($urandom), 4'h2, 12'($urandom)};
        expSel = 4'b0100; nAcc = 1; expErr = 1'b0;
        expData = wr ? 32'h0 : ((addr == 32'h0000_2010) ? 32'hDEAD_BEEF : (addr ^ 32'h5A5A_0000));
      end else if (kind == 8) begin
        addr = {16'($urandom), 4'($urandom_range(4, 15)), 12'($urandom)};
        expSel = 4'b0000; nAcc = 0; expErr = 1'b1; expData = 32'h0; dec = 1'b1;
      end else begin
        addr = {16'($urandom), 4'h1, 12'($urandom)};
        expSel = 4'b0010; nAcc = TIMEOUT; expErr = 1'b1; expData = 32'h0;
      end
      runTxn(wr, addr, wd, expSel, lat, ps, pe, rl, err, rd, st, po, sr);
      nChecks++; if (lat !== (dec ? 2 : 2 + nAcc)) begin nFails++; $display("[TB] FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, dec ? 2 : 2 + nAcc); end
      nChecks++; if (err !== expErr || rd !== expData) begin nFails++; $display("[TB] FAIL rnd_rsp[%0d]: got e=%0b d=%0h expected %0b/%0h", i, err, rd, expErr, expData); end
      nChecks++; if (pe !== nAcc || ps !== (dec ? 0 : nAcc + 1)) begin nFails++; $display("[TB] FAIL rnd_cycles[%0d]: got pen=%0d psel=%0d expected %0d/%0d", i, pe, ps, nAcc, dec ? 0 : nAcc + 1); end
      nChecks++; if (st !== 1'b1 || po !== 1'b1 || sr !== 4'h0) begin nFails++; $display("[TB] FAIL rnd_bus[%0d]: got stable=%0b pulse=%0b sel=%0h expected 1/1/0", i, st, po, sr); end
    end
  endtask

  task automatic test_reset_mid_transfer();
    int guard, rspSeen, lat, ps, pe, rl; logic err, st, po; logic [31:0] rd; logic [3:0] sr;
    @(negedge PCLK);
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge PCLK); guard++; end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4; req_wdata = 32'h77;
    @(negedge PCLK);
    req_valid = 1'b0;
    @(negedge PCLK);
    nChecks++; if (PENABLE !== 1'b1 || PSEL !== 4'b0001) begin nFails++; $display("[TB] FAIL rst_mid_in_access: got en=%0b sel=%0h expected 1/1", PENABLE, PSEL); end
    PRESET = 1'b1;
    @(negedge PCLK);
    rspSeen = rsp_valid ? 1 : 0;
    nChecks++; if (PSEL !== 4'h0 || PENABLE !== 1'b0) begin nFails++; $display("[TB] FAIL rst_mid_bus: got sel=%0h en=%0b expected 0/0", PSEL, PENABLE); end
    PRESET = 1'b0;
    @(negedge PCLK);
    nChecks++; if (req_ready !== 1'b1) begin nFails++; $display("[TB] FAIL rst_mid_ready: got %0b expected 1", req_ready); end
    repeat (4) begin
      if (rsp_valid) rspSeen++;
      @(negedge PCLK);
    end
    nChecks++; if (rspSeen !== 0) begin nFails++; $display("[TB] FAIL rst_mid_no_rsp: got %0d pulses expected 0", rspSeen); end
    runTxn(1'b1, 32'h4, 32'h3C, 4'b0001, lat, ps, pe, rl, err, rd, st, po, sr);
    nChecks++; if (lat !== 4 || err !== 1'b0 || st !== 1'b1) begin nFails++; $display("[TB] FAIL rst_mid_new_write: got lat=%0d e=%0b stable=%0b expected 4/0/1", lat, err, st); end
    runTxn(1'b0, 32'h8, 32'h0, 4'b0001, lat, ps, pe, rl, err, rd, st, po, sr);
    nChecks++; if (rd !== 32'h3C || err !== 1'b0) begin nFails++; $display("[TB] FAIL rst_mid_pop: got e=%0b d=%0h expected 0/3c", err, rd); end
  endtask

  task automatic checkOutput();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
  endtask

  initial begin
    test_reset();
    test_fifo();
    test_zero_wait();
    test_back_to_back();
    test_timeout();
    test_decode();
    test_timeout_boundary();
    test_random();
    test_reset_mid_transfer();
    checkOutput();
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
